// File: rtl/mac8_acc_commit.sv
// mac8_acc_commit
//   Commit buffer that sits behind the mac8 SIMD MAC unit. The MAC unit
//   produces speculative next-accumulator values tagged with a transaction
//   id. They queue here in order until the commit port retires them into
//   the architectural accumulator. A flush throws away everything that has
//   not retired. Values pass through unmodified. No arithmetic is done.
//
// Parameters
//   DEPTH          number of speculative entries (power of two, 2..16)
//   TRANS_ID_BITS  width of the transaction tag
//
// Ports
//   clk_i              clock, all state updates on the rising edge
//   rst_ni             asynchronous active-low reset
//   spec_valid_i       speculative result valid (push request)
//   spec_acc_i         speculative accumulator value
//   spec_trans_id_i    tag of the speculative result
//   spec_ready_o       a push can be accepted this cycle
//   commit_i           retire the oldest entry
//   commit_trans_id_i  tag the commit port expects at the head
//   flush_i            discard all speculative entries
//   spec_acc_o         youngest speculative value, or arch_acc_o when empty
//   arch_acc_o         committed accumulator
//   count_o            number of valid entries
//   mismatch_o         one-cycle pulse: committed tag differed from head tag
//   commit_err_o       one-cycle pulse: commit arrived while empty
module mac8_acc_commit #(
  parameter int DEPTH         = 4,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     spec_valid_i,
  input  logic [31:0]              spec_acc_i,
  input  logic [TRANS_ID_BITS-1:0] spec_trans_id_i,
  output logic                     spec_ready_o,
  input  logic                     commit_i,
  input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
  input  logic                     flush_i,
  output logic [31:0]              spec_acc_o,
  output logic [31:0]              arch_acc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     mismatch_o,
  output logic                     commit_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage: accumulator value and tag, indexed by the pointers.
  logic [31:0]              acc_mem [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      arch_acc;
  logic             mismatch;
  logic             commit_err;

  logic             empty;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] youngest_ptr;

  assign empty = (count == '0);

  // Ready depends only on the registered count. A commit in the same cycle
  // does not open a slot for the push, so nothing combinational runs from
  // commit_i to spec_ready_o.
  assign spec_ready_o = (count < FULL_CNT);

  assign push = spec_valid_i && spec_ready_o && !flush_i;
  assign pop  = commit_i && !empty;

  // The pointers wrap naturally because DEPTH is a power of two.
  assign youngest_ptr = wr_ptr - 1'b1;

  // NOTE: always_comb gives every output a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    spec_acc_o = arch_acc;
    if (!empty) spec_acc_o = acc_mem[youngest_ptr];
  end

  assign arch_acc_o   = arch_acc;
  assign count_o      = count;
  assign mismatch_o   = mismatch;
  assign commit_err_o = commit_err;

  // NOTE: the entry storage has no reset. An entry is only read once count
  // shows it is valid, so its contents before the first push do not matter,
  // and leaving reset off lets the array map onto plain registers or RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      acc_mem[wr_ptr] <= spec_acc_i;
      id_mem[wr_ptr]  <= spec_trans_id_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. That way every
  // right-hand side sees the value from before the clock edge, whatever the
  // order of the statements.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      arch_acc   <= '0;
      mismatch   <= 1'b0;
      commit_err <= 1'b0;
    end else begin
      mismatch   <= pop && (commit_trans_id_i != id_mem[rd_ptr]);
      commit_err <= commit_i && empty;

      // The commit retires before any flush, so a flush never hides a pop.
      if (pop) arch_acc <= acc_mem[rd_ptr];

      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
